// File: rtl/stream_pkg.sv
// Shared types and helpers for the stream packer: FSM state encoding and a
// constant-evaluable ceil(log2) used to size lane counters.
package stream_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } packer_state_t;

    localparam int DEFAULT_DATA_WIDTH = 4;
    localparam int DEFAULT_RATIO      = 4;

    // Number of bits needed to encode values 0..value-1 (ceil(log2(value))).
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // Lane-count width for the default ratio; the packer derives its own from RATIO.
    localparam int LANE_CNT_W = clog2(DEFAULT_RATIO + 1);

endpackage

// File: rtl/stream_packer.sv
// Packs RATIO consecutive DATA_WIDTH-bit items into one word, first item in the LSB lane.
// Optional partial-word flush and out_count port are enabled by STREAM_PACKER_FLUSH_EN.
module stream_packer
    import stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int RATIO      = DEFAULT_RATIO,   // legal range 2..16
    localparam int CNT_W     = clog2(RATIO + 1),
    localparam int OUT_W     = DATA_WIDTH * RATIO
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [OUT_W-1:0]      out_data,
    input  logic                  out_ready
`ifdef STREAM_PACKER_FLUSH_EN
   ,input  logic                  flush,
    output logic [CNT_W-1:0]      out_count
`endif
);

    packer_state_t         state_q;
    logic [CNT_W-1:0]      count_q;
    logic [DATA_WIDTH-1:0] lanes_q [RATIO];

    logic                  accept;
    logic                  last_item;
    logic                  flush_req;
    logic                  flush_fire;
    logic [CNT_W-1:0]      count_inc;
    logic [CNT_W-1:0]      count_after;

    // In FULL the slot frees up exactly when the held word leaves, so in_ready
    // follows out_ready there; it never looks at in_valid.
    assign in_ready  = (state_q == COLLECT) || out_ready;
    assign out_valid = (state_q == FULL);

    assign accept      = in_valid && in_ready;
    assign count_inc   = count_q + CNT_W'(1);
    assign count_after = accept ? count_inc : count_q;
    assign last_item   = (state_q == COLLECT) && accept && (count_q == CNT_W'(RATIO - 1));

`ifdef STREAM_PACKER_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    // A flush that coincides with the word-completing item is just a normal full word.
    assign flush_fire = (state_q == COLLECT) && flush_req && !last_item
                        && (count_after != '0);

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        out_data = '0;
        for (int i = 0; i < RATIO; i++) begin
            out_data[i*DATA_WIDTH +: DATA_WIDTH] = lanes_q[i];
        end
    end

    // NOTE: the lane array is reset (not left X) because out_data must read 0 after reset
    // and unused lanes of a partial word must read 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q <= COLLECT;
            count_q <= '0;
            for (int i = 0; i < RATIO; i++) begin
                lanes_q[i] <= '0;
            end
`ifdef STREAM_PACKER_FLUSH_EN
            out_count <= '0;
`endif
        end else begin
            case (state_q)
                COLLECT: begin
                    if (accept) begin
                        for (int i = 0; i < RATIO; i++) begin
                            if (count_q == CNT_W'(i)) begin
                                lanes_q[i] <= in_data;
                            end
                        end
                    end
                    if (last_item) begin
                        state_q <= FULL;
                        count_q <= '0;
`ifdef STREAM_PACKER_FLUSH_EN
                        out_count <= CNT_W'(RATIO);
`endif
                    end else if (flush_fire) begin
                        state_q <= FULL;
                        count_q <= '0;
`ifdef STREAM_PACKER_FLUSH_EN
                        out_count <= count_after;
`endif
                    end else if (accept) begin
                        count_q <= count_inc;
                    end
                end

                FULL: begin
                    if (out_ready) begin
                        // Word leaves; a same-cycle item starts the next word in lane 0.
                        state_q <= COLLECT;
                        for (int i = 0; i < RATIO; i++) begin
                            lanes_q[i] <= '0;
                        end
                        if (in_valid) begin
                            lanes_q[0] <= in_data;
                            count_q    <= CNT_W'(1);
                        end else begin
                            count_q    <= '0;
                        end
`ifdef STREAM_PACKER_FLUSH_EN
                        out_count <= '0;
`endif
                    end
                end

                default: begin
                    state_q <= COLLECT;
                    count_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_packer.sv
// Scoreboard bench for stream_packer (DATA_WIDTH=4, RATIO=4): directed cases plus random traffic.
// Flush cases are exercised when STREAM_PACKER_FLUSH_EN is defined.
module tb_stream_packer;
    import stream_pkg::*;

    localparam int DW    = 4;
    localparam int RATIO = 4;
    localparam int W     = DW * RATIO;
    localparam int CW    = clog2(RATIO + 1);

    typedef struct {
        logic [W-1:0] data;
        int           count;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic          flush;
    logic [CW-1:0] out_count;

    int checks;
    int errors;

    exp_t          exp_q[$];
    logic [DW-1:0] part[$];
    bit            held;
    bit            hold_prev;
    logic [W-1:0]  prev_data;

    stream_packer #(.DATA_WIDTH(DW), .RATIO(RATIO)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef STREAM_PACKER_FLUSH_EN
       ,.flush     (flush),
        .out_count (out_count)
`endif
    );

`ifndef STREAM_PACKER_FLUSH_EN
    assign out_count = '0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Pack a list of items, first item into the least-significant lane.
    function automatic logic [W-1:0] pack_items(input logic [DW-1:0] items[$]);
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < items.size(); i++) begin
            w = w | (W'(items[i]) << (i * DW));
        end
        return w;
    endfunction

    // Reference model + monitor: samples on the falling edge, mid-cycle.
    always @(negedge clk) begin
        bit   held_now;
        bit   exp_ready;
        bit   flush_s;
        exp_t e;
        if (!reset) begin
            part.delete();
            exp_q.delete();
            held      = 1'b0;
            hold_prev = 1'b0;
            check("reset_out_valid", 64'(out_valid), 64'd0);
            check("reset_out_data", 64'(out_data), 64'd0);
        end else begin
            held_now  = held;
            exp_ready = !held_now || out_ready;
`ifdef STREAM_PACKER_FLUSH_EN
            flush_s = flush;
`else
            flush_s = 1'b0;
`endif
            check("out_valid", 64'(out_valid), 64'(held_now));
            check("in_ready", 64'(in_ready), 64'(exp_ready));
            if (hold_prev) check("hold_data", 64'(out_data), 64'(prev_data));

            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected none at %0t", out_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 64'(out_data), 64'(e.data));
`ifdef STREAM_PACKER_FLUSH_EN
                    check("out_count", 64'(out_count), 64'(e.count));
`endif
                end
                held = 1'b0;
            end
            hold_prev = out_valid && !out_ready;
            prev_data = out_data;

            if (in_valid && exp_ready) part.push_back(in_data);
            if (part.size() == RATIO) begin
                e.data  = pack_items(part);
                e.count = RATIO;
                exp_q.push_back(e);
                part.delete();
                held = 1'b1;
            end else if (flush_s && !held_now && part.size() > 0) begin
                e.data  = pack_items(part);
                e.count = part.size();
                exp_q.push_back(e);
                part.delete();
                held = 1'b1;
            end
        end
    end

    task automatic push(input logic [DW-1:0] d);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = d;
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        held      = 1'b0;
        hold_prev = 1'b0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("ready_after_reset", 64'(in_ready), 64'd1);

        // Single word, then two back-to-back words.
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) push(DW'(i));
        idle(3);
        for (int i = 1; i <= 8; i++) push(DW'(i));
        idle(3);

        // Backpressure: word 4321 held while item 5 waits.
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) push(DW'(i));
        push(DW'(5));
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_out_data", 64'(out_data), 64'h4321);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 6; i <= 8; i++) push(DW'(i));
        idle(3);

`ifdef STREAM_PACKER_FLUSH_EN
        // Partial word via flush, then a flush with nothing collected.
        push(DW'(4'hA));
        push(DW'(4'hB));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b1;
        idle(3);
        @(posedge clk);
        #1;
        flush = 1'b1;
        idle(3);
`endif

        // Reset mid-word discards the partial lanes.
        for (int i = 1; i <= 3; i++) push(DW'(4'hF));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        check("async_reset_valid", 64'(out_valid), 64'd0);
        check("async_reset_data", 64'(out_data), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        push(DW'(4'h9));
        push(DW'(4'hC));
        push(DW'(4'h2));
        push(DW'(4'h7));
        idle(3);

        // Random traffic with random backpressure.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = DW'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
`ifdef STREAM_PACKER_FLUSH_EN
            flush     = ($urandom_range(0, 9) == 0);
`endif
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
